// File: rtl/uart_ns_rx_ctrl.sv
// uart_ns_rx_ctrl
// Receive-side controller for the UART peripheral: buffers bytes from the
// receiver in a circular FIFO, keeps sticky error status, runs an idle-line
// character timeout and drives one registered interrupt line.
module uart_ns_rx_ctrl #(
    parameter int UART_DATA_SIZE     = 8,
    parameter int FIFO_DEPTH         = 16,
    parameter int TIMEOUT_BITS       = 40,
    parameter int UART_BAUD_DIV_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [UART_DATA_SIZE-1:0]       rx_data_i,
    input  logic                            rx_valid_i,
    input  logic                            rx_frame_err_i,
    input  logic [UART_BAUD_DIV_SIZE-1:0]   baud_div_i,
    input  logic                            rx_en_i,
    input  logic [$clog2(FIFO_DEPTH):0]     thresh_i,
    input  logic [3:0]                      irq_en_i,
    input  logic                            flush_i,
    input  logic                            clr_status_i,
    input  logic                            rd_pop_i,
    output logic [UART_DATA_SIZE-1:0]       rd_data_o,
    output logic                            rd_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            full_o,
    output logic                            overrun_o,
    output logic                            frame_err_o,
    output logic                            timeout_o,
    output logic                            irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = UART_BAUD_DIV_SIZE;
    localparam int BW = $clog2(TIMEOUT_BITS + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] TIMEOUT_C = BW'(TIMEOUT_BITS);

    // Edge detection state and the one-cycle-delayed events it produces
    logic                      validPrev_q;
    logic                      ferrPrev_q;
    logic                      pushPend_q;
    logic                      ferrPend_q;
    logic [UART_DATA_SIZE-1:0] dataHold_q;

    // FIFO storage and bookkeeping
    logic [UART_DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]             rdPtr_q;
    logic [AW-1:0]             wrPtr_q;
    logic [CW-1:0]             count_q;
    logic [CW-1:0]             count_d;

    // Status, timeout and interrupt state
    logic                      overrun_q;
    logic                      frameErr_q;
    logic                      timeout_q;
    logic                      irq_q;
    logic [DW-1:0]             clkCnt_q;
    logic [BW-1:0]             bitCnt_q;

    // Combinational helpers
    logic          isFull;
    logic          isEmpty;
    logic          popEff;
    logic          pushEff;
    logic          overrunSet;
    logic          timeoutSet;
    logic          timerClear;
    logic [DW-1:0] divEff;
    logic          irqNext;

    assign isFull     = (count_q == DEPTH_C);
    assign isEmpty    = (count_q == '0);
    assign popEff     = rd_pop_i & ~isEmpty;
    // A push into a full FIFO is still accepted when a pop frees the slot
    assign pushEff    = pushPend_q & (~isFull | popEff);
    assign overrunSet = pushPend_q & isFull & ~popEff & ~flush_i;
    assign timeoutSet = (bitCnt_q == TIMEOUT_C) & ~isEmpty & ~popEff & ~flush_i;
    assign timerClear = pushPend_q | popEff | flush_i | isEmpty;
    assign divEff     = (baud_div_i == '0) ? DW'(1) : baud_div_i;

    assign irqNext = (irq_en_i[0] & (thresh_i != '0) & (count_q >= thresh_i))
                   | (irq_en_i[1] & overrun_q)
                   | (irq_en_i[2] & frameErr_q)
                   | (irq_en_i[3] & timeout_q);

    // Next fill level: flush dominates, a simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (pushEff && !popEff) begin
            count_d = count_q + CW'(1);
        end else if (popEff && !pushEff) begin
            count_d = count_q - CW'(1);
        end
    end

    // Register the raw receiver strobes and turn rising edges into events one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validPrev_q <= 1'b0;
            ferrPrev_q  <= 1'b0;
            pushPend_q  <= 1'b0;
            ferrPend_q  <= 1'b0;
            dataHold_q  <= '0;
        end else begin
            validPrev_q <= rx_valid_i;
            ferrPrev_q  <= rx_frame_err_i;
            pushPend_q  <= rx_valid_i & ~validPrev_q & rx_en_i;
            ferrPend_q  <= rx_frame_err_i & ~ferrPrev_q & rx_en_i;
            dataHold_q  <= rx_data_i;
        end
    end

    // FIFO storage, pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                rdPtr_q <= '0;
                wrPtr_q <= '0;
            end else begin
                if (pushEff) begin
                    mem_q[wrPtr_q] <= dataHold_q;
                    wrPtr_q        <= wrPtr_q + AW'(1);
                end
                if (popEff) begin
                    rdPtr_q <= rdPtr_q + AW'(1);
                end
            end
        end
    end

    // Idle-line timer: a clock divider producing bit ticks and a saturating bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkCnt_q <= '0;
            bitCnt_q <= '0;
        end else if (timerClear) begin
            clkCnt_q <= '0;
            bitCnt_q <= '0;
        end else if (clkCnt_q >= divEff - DW'(1)) begin
            clkCnt_q <= '0;
            if (bitCnt_q != TIMEOUT_C) begin
                bitCnt_q <= bitCnt_q + BW'(1);
            end
        end else begin
            clkCnt_q <= clkCnt_q + DW'(1);
        end
    end

    // Sticky status flags; a set event in the same cycle as a clear keeps the flag high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (overrunSet) begin
                overrun_q <= 1'b1;
            end else if (clr_status_i) begin
                overrun_q <= 1'b0;
            end

            if (ferrPend_q) begin
                frameErr_q <= 1'b1;
            end else if (clr_status_i) begin
                frameErr_q <= 1'b0;
            end

            if (timeoutSet) begin
                timeout_q <= 1'b1;
            end else if (clr_status_i || popEff || flush_i) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Interrupt is the registered OR of the enabled sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irqNext;
        end
    end

    assign rd_data_o   = mem_q[rdPtr_q];
    assign rd_valid_o  = ~isEmpty;
    assign count_o     = count_q;
    assign full_o      = isFull;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frameErr_q;
    assign timeout_o   = timeout_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_ns_rx_ctrl.sv
// tb_uart_ns_rx_ctrl
// Scoreboard bench for the UART receive controller: every accepted byte is
// queued when it is driven and compared when it reaches the FIFO head.
module tb_uart_ns_rx_ctrl;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_frame_err_i;
    logic [15:0] baud_div_i;
    logic        rx_en_i;
    logic [4:0]  thresh_i;
    logic [3:0]  irq_en_i;
    logic        flush_i;
    logic        clr_status_i;
    logic        rd_pop_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        overrun_o;
    logic        frame_err_o;
    logic        timeout_o;
    logic        irq_o;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  expQ[$];

    uart_ns_rx_ctrl #(
        .UART_DATA_SIZE(8),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_BITS(40),
        .UART_BAUD_DIV_SIZE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data_i(rx_data_i),
        .rx_valid_i(rx_valid_i),
        .rx_frame_err_i(rx_frame_err_i),
        .baud_div_i(baud_div_i),
        .rx_en_i(rx_en_i),
        .thresh_i(thresh_i),
        .irq_en_i(irq_en_i),
        .flush_i(flush_i),
        .clr_status_i(clr_status_i),
        .rd_pop_i(rd_pop_i),
        .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o),
        .count_o(count_o),
        .full_o(full_o),
        .overrun_o(overrun_o),
        .frame_err_o(frame_err_o),
        .timeout_o(timeout_o),
        .irq_o(irq_o)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one rising edge of rx_valid; it commits at the second edge
    task automatic pushByte(input logic [7:0] b, input bit accepted);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        tick();
        if (accepted) expQ.push_back(b);
    endtask

    // Compare the FIFO head with the scoreboard, then pop it
    task automatic popAndScore();
        logic [7:0] exp;
        nChecks++;
        if (expQ.size() == 0) begin
            nFails++;
            $display("[TB] FAIL pop_underflow: scoreboard empty, rd_valid_o=%0b", rd_valid_o);
        end else begin
            exp = expQ.pop_front();
            if (rd_valid_o !== 1'b1 || rd_data_o !== exp) begin
                nFails++;
                $display("[TB] FAIL pop_data: got valid=%0b data=%02h, expected valid=1 data=%02h",
                         rd_valid_o, rd_data_o, exp);
            end
        end
        rd_pop_i = 1'b1;
        tick();
        rd_pop_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        nChecks++;
        if ({count_o, rd_valid_o, full_o, overrun_o, frame_err_o, timeout_o, irq_o} !== 11'b0) begin
            nFails++;
            $display("[TB] FAIL reset_state: count=%0d valid=%0b full=%0b ovr=%0b ferr=%0b to=%0b irq=%0b, expected all 0",
                     count_o, rd_valid_o, full_o, overrun_o, frame_err_o, timeout_o, irq_o);
        end
        nChecks++;
        if (rd_data_o !== 8'h00) begin
            nFails++;
            $display("[TB] FAIL reset_data: got %02h, expected 00", rd_data_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        pushByte(8'hA5, 1'b1);
        pushByte(8'h3C, 1'b1);
        nChecks++;
        if (count_o !== 5'd2) begin
            nFails++;
            $display("[TB] FAIL basic_count2: got %0d, expected 2", count_o);
        end
        popAndScore();
        nChecks++;
        if (count_o !== 5'd1) begin
            nFails++;
            $display("[TB] FAIL basic_count1: got %0d, expected 1", count_o);
        end
        popAndScore();
        nChecks++;
        if (count_o !== 5'd0 || rd_valid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL basic_empty: count=%0d valid=%0b, expected 0/0", count_o, rd_valid_o);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= DEPTH; i++) begin
            pushByte(8'(i), i < DEPTH);
        end
        nChecks++;
        if (full_o !== 1'b1 || overrun_o !== 1'b1 || count_o !== 5'd16) begin
            nFails++;
            $display("[TB] FAIL overrun_flags: full=%0b ovr=%0b count=%0d, expected 1/1/16",
                     full_o, overrun_o, count_o);
        end
        clr_status_i = 1'b1;
        tick();
        clr_status_i = 1'b0;
        nChecks++;
        if (overrun_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL overrun_clear: got %0b, expected 0", overrun_o);
        end
        while (expQ.size() > 0) popAndScore();
        nChecks++;
        if (rd_valid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL overrun_drained: rd_valid_o=%0b, expected 0", rd_valid_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) pushByte(8'h20 + 8'(i), 1'b1);
        // Push 0x55 so that it commits on the same edge as a pop
        rx_data_i  = 8'h55;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        exp = expQ.pop_front();
        nChecks++;
        if (rd_data_o !== exp) begin
            nFails++;
            $display("[TB] FAIL fullpp_head: got %02h, expected %02h", rd_data_o, exp);
        end
        rd_pop_i = 1'b1;
        tick();
        rd_pop_i = 1'b0;
        expQ.push_back(8'h55);
        nChecks++;
        if (count_o !== 5'd16 || overrun_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL fullpp_state: count=%0d ovr=%0b, expected 16/0", count_o, overrun_o);
        end
        while (expQ.size() > 0) popAndScore();
    endtask

    task automatic test_threshold_irq();
        thresh_i = 5'd4;
        irq_en_i = 4'b0001;
        for (int i = 0; i < 3; i++) pushByte(8'h60 + 8'(i), 1'b1);
        nChecks++;
        if (irq_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL thr_below: irq=%0b, expected 0", irq_o);
        end
        pushByte(8'h63, 1'b1);
        nChecks++;
        if (count_o !== 5'd4 || irq_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL thr_lag: count=%0d irq=%0b, expected 4/0", count_o, irq_o);
        end
        tick();
        nChecks++;
        if (irq_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL thr_rise: irq=%0b, expected 1", irq_o);
        end
        popAndScore();
        nChecks++;
        if (irq_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL thr_fall_lag: irq=%0b, expected 1", irq_o);
        end
        tick();
        nChecks++;
        if (irq_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL thr_fall: irq=%0b, expected 0", irq_o);
        end
        while (expQ.size() > 0) popAndScore();
        irq_en_i = 4'b0000;
        thresh_i = 5'd0;
    endtask

    task automatic test_timeout();
        baud_div_i = 16'd10;
        pushByte(8'h77, 1'b1);
        repeat (400) tick();
        nChecks++;
        if (timeout_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL timeout_early: got %0b at 400 cycles, expected 0", timeout_o);
        end
        tick();
        nChecks++;
        if (timeout_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL timeout_set: got %0b at 401 cycles, expected 1", timeout_o);
        end
        popAndScore();
        nChecks++;
        if (timeout_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL timeout_pop_clear: got %0b, expected 0", timeout_o);
        end
        repeat (500) tick();
        nChecks++;
        if (timeout_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL timeout_empty: got %0b with empty FIFO, expected 0", timeout_o);
        end
    endtask

    task automatic test_frame_err();
        pushByte(8'h11, 1'b1);
        rx_frame_err_i = 1'b1;
        tick();
        rx_frame_err_i = 1'b0;
        tick();
        nChecks++;
        if (frame_err_o !== 1'b1 || count_o !== 5'd1) begin
            nFails++;
            $display("[TB] FAIL ferr_set: ferr=%0b count=%0d, expected 1/1", frame_err_o, count_o);
        end
        clr_status_i = 1'b1;
        tick();
        clr_status_i = 1'b0;
        nChecks++;
        if (frame_err_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ferr_clear: got %0b, expected 0", frame_err_o);
        end
        // New frame error commits on the same edge as the clear
        rx_frame_err_i = 1'b1;
        tick();
        rx_frame_err_i = 1'b0;
        clr_status_i   = 1'b1;
        tick();
        clr_status_i   = 1'b0;
        nChecks++;
        if (frame_err_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL ferr_set_wins: got %0b, expected 1", frame_err_o);
        end
        clr_status_i = 1'b1;
        tick();
        clr_status_i = 1'b0;
        popAndScore();
    endtask

    task automatic test_flush();
        pushByte(8'h81, 1'b0);
        pushByte(8'h82, 1'b0);
        rx_data_i  = 8'h83;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
        flush_i    = 1'b1;
        tick();
        flush_i    = 1'b0;
        nChecks++;
        if (count_o !== 5'd0 || rd_valid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL flush_push: count=%0d valid=%0b, expected 0/0", count_o, rd_valid_o);
        end
    endtask

    task automatic test_rx_disable();
        pushByte(8'h90, 1'b1);
        rx_en_i = 1'b0;
        pushByte(8'h91, 1'b0);
        rx_frame_err_i = 1'b1;
        tick();
        rx_frame_err_i = 1'b0;
        tick();
        nChecks++;
        if (count_o !== 5'd1 || frame_err_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL disable_ignore: count=%0d ferr=%0b, expected 1/0", count_o, frame_err_o);
        end
        popAndScore();
        rx_en_i = 1'b1;
    endtask

    task automatic test_reset_mid();
        pushByte(8'hC1, 1'b0);
        pushByte(8'hC2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        nChecks++;
        if (count_o !== 5'd0 || rd_data_o !== 8'h00) begin
            nFails++;
            $display("[TB] FAIL reset_async: count=%0d data=%02h, expected 0/00", count_o, rd_data_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Scenario sequence
    initial begin
        rst            = 1'b1;
        rx_data_i      = 8'h00;
        rx_valid_i     = 1'b0;
        rx_frame_err_i = 1'b0;
        baud_div_i     = 16'd10;
        rx_en_i        = 1'b1;
        thresh_i       = 5'd0;
        irq_en_i       = 4'b0000;
        flush_i        = 1'b0;
        clr_status_i   = 1'b0;
        rd_pop_i       = 1'b0;

        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_threshold_irq();
        test_timeout();
        test_frame_err();
        test_flush();
        test_rx_disable();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
